// File: rtl/uart_rx_packetizer_if.sv
// Committed-payload byte stream from uart_rx_packetizer to the command decoder.
// The master drives data/last/valid; the slave answers with ready.
interface uart_rx_packetizer_if;
    logic [7:0] pkt_data;
    logic       pkt_last;
    logic       pkt_valid;
    logic       pkt_ready;

    modport master (output pkt_data, output pkt_last, output pkt_valid, input pkt_ready);
    modport slave  (input pkt_data, input pkt_last, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/uart_rx_packetizer.sv
// Frames the uart_rx byte stream into SYNC/LEN/payload/CSUM packets, buffering payload speculatively.
// Define UART_PKT_STATS_EN to add the drop_count/pkt_count statistics outputs.
module uart_rx_packetizer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         FIFO_DEPTH     = 32,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_ready,
    input  logic                        rx_error,
    input  logic [7:0]                  rx_val,
    uart_rx_packetizer_if.master        pkt,
`ifdef UART_PKT_STATS_EN
    output logic [7:0]                  drop_count,
    output logic [7:0]                  pkt_count,
    output logic                        pkt_drop
`else
    output logic                        pkt_drop
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_SYNC    = 2'd0;
    localparam logic [1:0] S_LEN     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_CSUM    = 2'd3;

    logic [1:0]    state, state_d;
    logic [PW-1:0] wr_ptr, wr_ptr_d, commit_ptr, rd_ptr;
    logic [PW-1:0] used, free;
    logic [7:0]    len, len_d, cnt, cnt_d, sum, sum_d, sum_next;
    logic [TW-1:0] tmo_cnt;
    logic          rx_ready_q, rx_error_q;
    logic          byte_evt, err_evt, tmo_hit, rd_fire, len_bad, last_byte;
    logic          drop_d, commit_evt, mem_we;
    logic [8:0]    mem [FIFO_DEPTH];

    assign byte_evt  = rx_ready & ~rx_ready_q;
    assign err_evt   = rx_error & ~rx_error_q;
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign used      = wr_ptr - rd_ptr;
    assign free      = PW'(FIFO_DEPTH) - used;
    assign sum_next  = sum + rx_val;
    assign last_byte = (cnt == len - 8'd1);
    // Space for the whole payload is reserved here, so the payload state can never overflow.
    assign len_bad   = (rx_val == 8'd0) || (32'(rx_val) > 32'(MAX_LEN)) || (32'(rx_val) > 32'(free));

    assign pkt.pkt_valid = (rd_ptr != commit_ptr);
    assign {pkt.pkt_last, pkt.pkt_data} = mem[rd_ptr[AW-1:0]];
    assign rd_fire = pkt.pkt_valid & pkt.pkt_ready;

    always_comb begin
        state_d    = state;
        wr_ptr_d   = wr_ptr;
        len_d      = len;
        cnt_d      = cnt;
        sum_d      = sum;
        drop_d     = 1'b0;
        commit_evt = 1'b0;
        mem_we     = 1'b0;
        if (err_evt) begin
            drop_d = (state != S_SYNC);
        end else if (byte_evt) begin
            case (state)
                S_SYNC: if (rx_val == SYNC_BYTE) state_d = S_LEN;
                S_LEN: begin
                    if (len_bad) begin
                        drop_d = 1'b1;
                    end else begin
                        len_d   = rx_val;
                        sum_d   = rx_val;
                        cnt_d   = 8'd0;
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr + PW'(1);
                    sum_d    = sum_next;
                    cnt_d    = cnt + 8'd1;
                    if (last_byte) state_d = S_CSUM;
                end
                default: begin
                    if (sum_next == 8'd0) commit_evt = 1'b1;
                    else                  drop_d     = 1'b1;
                    state_d = S_SYNC;
                end
            endcase
        end else if (tmo_hit && state != S_SYNC) begin
            drop_d = 1'b1;
        end
        // Rollback only rewinds the speculative write side; rd_ptr and committed data are untouched.
        if (drop_d) begin
            wr_ptr_d = commit_ptr;
            state_d  = S_SYNC;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_SYNC;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            len        <= '0;
            cnt        <= '0;
            sum        <= '0;
            tmo_cnt    <= '0;
            pkt_drop   <= 1'b0;
            rx_ready_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            state      <= state_d;
            wr_ptr     <= wr_ptr_d;
            len        <= len_d;
            cnt        <= cnt_d;
            sum        <= sum_d;
            pkt_drop   <= drop_d;
            rx_ready_q <= rx_ready;
            rx_error_q <= rx_error;
            if (commit_evt) commit_ptr <= wr_ptr;
            if (rd_fire)    rd_ptr     <= rd_ptr + PW'(1);
            if (state == S_SYNC || byte_evt) tmo_cnt <= '0;
            else if (!tmo_hit)               tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // NOTE: the payload RAM has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= {last_byte, rx_val};
    end

`ifdef UART_PKT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= 8'd0;
            pkt_count  <= 8'd0;
        end else begin
            if (pkt_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (commit_evt)                      pkt_count  <= pkt_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// Self-checking bench for uart_rx_packetizer: directed frames plus randomized packets against a queue model.
module tb_uart_rx_packetizer;

    localparam logic [7:0] SYNC  = 8'hA5;
    localparam int         MAXL  = 16;
    localparam int         DEPTH = 32;
    localparam int         TMO   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx_error = 1'b0;
    logic [7:0] rx_val = 8'h00;
    logic       pkt_drop;

    uart_rx_packetizer_if pkt_if ();

    uart_rx_packetizer #(
        .SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_error(rx_error), .rx_val(rx_val),
        .pkt(pkt_if), .pkt_drop(pkt_drop)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         drop_seen = 0;
    int         exp_drops = 0;
    int         rd_count = 0;
    int         ready_mode = 0;   // 0 = stalled, 1 = always ready, 2 = random
    logic [8:0] exp_q[$];         // {last, data} committed but not yet consumed
    logic [8:0] pend_q[$];        // payload of the frame in flight
    logic [7:0] pl_q[$];          // payload bytes for the next send_pkt

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pkt_if.pkt_ready = 1'b0;
            1:       pkt_if.pkt_ready = 1'b1;
            default: pkt_if.pkt_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Consumer monitor: a handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_drop) drop_seen++;
            if (pkt_if.pkt_valid && pkt_if.pkt_ready) begin
                rd_count++;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(pkt_if.pkt_valid), 32'd0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("data", 32'(pkt_if.pkt_data), 32'(e[7:0]));
                    check("last", 32'(pkt_if.pkt_last), 32'(e[8]));
                end
            end
        end
    end

    // Raises rx_ready one cycle after an edge; free_snap is the buffer space the DUT sees at that sample.
    task automatic send_byte(input logic [7:0] b, input bit commit, output int free_snap);
        @(posedge clk); #1;
        free_snap = DEPTH - exp_q.size();
        rx_val   = b;
        rx_ready = 1'b1;
        if (commit) while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 rx_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] len, input bit corrupt);
        int         fs;
        logic [7:0] s;
        send_byte(SYNC, 1'b0, fs);
        send_byte(len, 1'b0, fs);
        if (len == 0 || int'(len) > MAXL || int'(len) > fs) begin
            exp_drops++;
        end else begin
            s = len;
            pend_q.delete();
            for (int i = 0; i < int'(len); i++) begin
                pend_q.push_back({i == int'(len) - 1, pl_q[i]});
                s = s + pl_q[i];
                send_byte(pl_q[i], 1'b0, fs);
            end
            s = 8'h00 - s;
            if (corrupt) begin
                send_byte(s + 8'h01, 1'b0, fs);
                pend_q.delete();
                exp_drops++;
            end else begin
                send_byte(s, 1'b1, fs);
            end
        end
        repeat (2) @(posedge clk);
        check("drop_count", 32'(drop_seen), 32'(exp_drops));
    endtask

    task automatic fill_random(input int len);
        pl_q.delete();
        for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
    endtask

    task automatic wait_drain();
        ready_mode = 1;
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs;
        int rd_before;
        logic [7:0] head;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(pkt_if.pkt_valid), 32'd0);
        check("reset_drop", 32'(pkt_drop), 32'd0);
        rst = 1'b0;
        ready_mode = 1;
        repeat (2) @(posedge clk);

        // Good packet A5 03 11 22 33 97.
        pl_q = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'd3, 1'b0);
        wait_drain();
        check("good_reads", 32'(rd_count), 32'd3);

        // Bad checksum A5 03 11 22 33 98.
        rd_before = rd_count;
        send_pkt(8'd3, 1'b1);
        repeat (5) @(posedge clk);
        #1 check("badcsum_valid", 32'(pkt_if.pkt_valid), 32'd0);
        check("badcsum_reads", 32'(rd_count), 32'(rd_before));

        // Garbage then sync: 00 FF A5 01 7E 81.
        send_byte(8'h00, 1'b0, fs);
        send_byte(8'hFF, 1'b0, fs);
        pl_q = '{8'h7E};
        send_pkt(8'd1, 1'b0);
        wait_drain();

        // Length violations followed by an intact packet.
        send_pkt(8'd0, 1'b0);
        send_pkt(8'(MAXL + 1), 1'b0);
        fill_random(MAXL);
        send_pkt(8'(MAXL), 1'b0);
        wait_drain();

        // Backpressure: two 15-byte packets fit, the third is refused at LEN.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        rd_before = rd_count;
        for (int p = 0; p < 3; p++) begin
            fill_random(15);
            send_pkt(8'd15, 1'b0);
        end
        check("bp_queued", 32'(exp_q.size()), 32'd30);
        head = exp_q[0][7:0];
        @(posedge clk); #1;
        check("bp_valid", 32'(pkt_if.pkt_valid), 32'd1);
        check("bp_head", 32'(pkt_if.pkt_data), 32'(head));
        repeat (5) @(posedge clk);
        #1 check("bp_hold", 32'(pkt_if.pkt_data), 32'(head));
        wait_drain();
        check("bp_reads", 32'(rd_count - rd_before), 32'd30);

        // Inter-byte timeout inside a packet.
        send_byte(SYNC, 1'b0, fs);
        send_byte(8'd2, 1'b0, fs);
        send_byte(8'h44, 1'b0, fs);
        repeat (TMO - 20) @(posedge clk);
        check("tmo_early", 32'(drop_seen), 32'(exp_drops));
        repeat (25) @(posedge clk);
        exp_drops++;
        check("tmo_drop", 32'(drop_seen), 32'(exp_drops));

        // rx_error pulse mid-payload, then an intact packet.
        send_byte(SYNC, 1'b0, fs);
        send_byte(8'd4, 1'b0, fs);
        send_byte(8'h01, 1'b0, fs);
        send_byte(8'h02, 1'b0, fs);
        rx_error = 1'b1;
        repeat (2) @(posedge clk);
        #1 rx_error = 1'b0;
        repeat (2) @(posedge clk);
        exp_drops++;
        check("err_drop", 32'(drop_seen), 32'(exp_drops));
        pl_q = '{8'h5A, 8'hC3};
        send_pkt(8'd2, 1'b0);
        wait_drain();

        // Reset mid-payload with committed data still waiting.
        ready_mode = 0;
        pl_q = '{8'h10, 8'h20};
        send_pkt(8'd2, 1'b0);
        send_byte(SYNC, 1'b0, fs);
        send_byte(8'd3, 1'b0, fs);
        send_byte(8'h99, 1'b0, fs);
        #1 check("pre_rst_valid", 32'(pkt_if.pkt_valid), 32'd1);
        rst = 1'b1;
        #1 check("rst_valid", 32'(pkt_if.pkt_valid), 32'd0);
        exp_q.delete();
        pend_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Randomized packets with random consumer backpressure.
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'hA4)), 1'b0, fs);
            len = $urandom_range(0, MAXL + 2);
            fill_random(len);
            send_pkt(8'(len), ($urandom_range(0, 4) == 0));
        end
        wait_drain();
        check("final_drops", 32'(drop_seen), 32'(exp_drops));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
